mux_arbiter: RTL and testbench

Two-requester round-robin arbiter that owns the select of the shared 2:1 datapath mux and drives the selected input onto the shared bus. It sits between two masters contending for one datapath resource, e.g. a memory port or write-back bus, and replaces a hard-wired select with a registered req/grant handshake. Grants are one-hot, registered, and held for as long as the owner keeps its request high. An optional hold limit forces rotation when the owner keeps the bus too long.

---
 rtl/mux_arbiter.sv | 156 +++++++++++++++
 tb/tb_mux_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// mux_arbiter
//   Two-requester round-robin arbiter that owns the select of a shared 2:1
//   datapath mux. Grants are one-hot and registered. Once granted, a
//   requester keeps the bus for as long as its request stays high.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     defined   - a hold counter forces rotation after MAX_HOLD consecutive
//                 grant cycles, but only while the other requester is waiting
//     undefined - the owner keeps the grant until it drops its request
//
// Parameters
//   width     data width of IN1, IN2 and OUT
//   MAX_HOLD  maximum consecutive grant cycles before forced rotation (>=1)
//
// Ports
//   CLK   in   clock, rising edge
//   RST   in   asynchronous reset, active-low
//   REQ0  in   request from requester 0
//   REQ1  in   request from requester 1
//   IN1   in   data from requester 0
//   IN2   in   data from requester 1
//   GNT0  out  grant to requester 0 (registered)
//   GNT1  out  grant to requester 1 (registered)
//   SEL   out  mux select, 0 -> IN1, 1 -> IN2 (registered)
//   OUT   out  SEL ? IN2 : IN1
//   BUSY  out  GNT0 | GNT1
//
// state | meaning
// ------+------------------------------------------
// IDLE  | no owner; SEL keeps its last value
// G0    | requester 0 owns the bus (GNT0=1, SEL=0)
// G1    | requester 1 owns the bus (GNT1=1, SEL=1)

module mux_arbiter #(
  parameter int width    = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [width-1:0] IN1,
  input  logic [width-1:0] IN2,
  output logic             GNT0,
  output logic             GNT1,
  output logic             SEL,
  output logic [width-1:0] OUT,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last;
  logic   sel_q;
  logic   force0;  // owner 0 must yield to a waiting requester 1
  logic   force1;  // owner 1 must yield to a waiting requester 0

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD - 1);

  logic [CW-1:0] hold_cnt;
  logic          at_lim;

  assign at_lim = (hold_cnt == HOLD_LIM);
  assign force0 = at_lim && REQ1;
  assign force1 = at_lim && REQ0;

  // Cleared on every grant entry; saturates at the limit so a lone owner
  // keeps the bus and yields at the first edge the other side asks.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_cnt <= '0;
    end else if ((state_nxt != state) && (state_nxt != IDLE)) begin
      hold_cnt <= '0;
    end else if ((state != IDLE) && !at_lim) begin
      hold_cnt <= hold_cnt + CW'(1);
    end
  end
`else
  logic unused_hold;

  assign force0      = 1'b0;
  assign force1      = 1'b0;
  assign unused_hold = (MAX_HOLD > 0);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (REQ0 && REQ1) begin
          state_nxt = last ? G0 : G1;
        end else if (REQ0) begin
          state_nxt = G0;
        end else if (REQ1) begin
          state_nxt = G1;
        end
      end
      G0: begin
        if (REQ0 && !force0) begin
          state_nxt = G0;
        end else if (REQ1) begin
          state_nxt = G1;
        end else begin
          state_nxt = IDLE;
        end
      end
      G1: begin
        if (REQ1 && !force1) begin
          state_nxt = G1;
        end else if (REQ0) begin
          state_nxt = G0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // SEL and LAST move only on grant entry, so SEL parks on the last owner
  // while idle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sel_q <= 1'b0;
      last  <= 1'b1;
    end else if ((state_nxt == G0) && (state != G0)) begin
      sel_q <= 1'b0;
      last  <= 1'b0;
    end else if ((state_nxt == G1) && (state != G1)) begin
      sel_q <= 1'b1;
      last  <= 1'b1;
    end
  end

  assign GNT0 = (state == G0);
  assign GNT1 = (state == G1);
  assign BUSY = GNT0 | GNT1;
  assign SEL  = sel_q;
  assign OUT  = sel_q ? IN2 : IN1;

endmodule

// File: tb/tb_mux_arbiter.sv
module tb_mux_arbiter;

  localparam int W       = 32;
  localparam int TB_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         req0, req1;
  logic [W-1:0] in1, in2;
  logic         gnt0, gnt1, sel, busy;
  logic [W-1:0] out;

  int checks = 0;
  int errors = 0;

  mux_arbiter #(.width(W), .MAX_HOLD(TB_HOLD)) dut (
    .CLK (clk),
    .RST (rst),
    .REQ0(req0),
    .REQ1(req1),
    .IN1 (in1),
    .IN2 (in2),
    .GNT0(gnt0),
    .GNT1(gnt1),
    .SEL (sel),
    .OUT (out),
    .BUSY(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the bus (-1 = nobody), who was granted last,
  // where the mux points, and how many cycles the owner has held it.
  int m_owner;
  int m_last;
  bit m_sel;
  int m_ten;

  function automatic void model_reset();
    m_owner = -1;
    m_last  = 1;
    m_sel   = 1'b0;
    m_ten   = 0;
  endfunction

  function automatic void model_step(input bit r0, input bit r1);
    bit r[2];
    int nw;
    int o;
    r[0] = r0;
    r[1] = r1;
    nw   = -1;
    if (m_owner < 0) begin
      if (r0 && r1)   nw = 1 - m_last;
      else if (r0)    nw = 0;
      else if (r1)    nw = 1;
    end else begin
      o = m_owner;
      if (r[o] && !(TO_EN && (m_ten >= TB_HOLD) && r[1-o])) nw = o;
      else if (r[1-o])                                    nw = 1 - o;
    end
    if (nw >= 0 && nw != m_owner) begin
      m_ten  = 1;
      m_last = nw;
      m_sel  = (nw == 1);
    end else if (nw >= 0) begin
      m_ten++;
    end
    m_owner = nw;
  endfunction

  function automatic logic [W+3:0] model_vec();
    return {m_owner == 0, m_owner == 1, m_sel, m_owner >= 0, (m_sel ? in2 : in1)};
  endfunction

  logic [W+3:0] dut_vec;
  assign dut_vec = {gnt0, gnt1, sel, busy, out};

  task automatic test_reset();
    rst  = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    in1  = $urandom;
    in2  = $urandom;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({gnt0, gnt1, sel, busy, out} !== {4'b0000, in1}) begin
      errors++;
      $display("FAIL reset_state: dut=%h exp=%h", {gnt0, gnt1, sel, busy, out}, {4'b0000, in1});
    end
    rst = 1'b1;
    @(posedge clk);
    model_step(1'b1, 1'b1);
    #1;
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL reset_first_tie: gnt=%b exp=10", {gnt0, gnt1});
    end
    checks++;
    if (dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL reset_model: dut=%h exp=%h", dut_vec, model_vec());
    end
  endtask

  task automatic test_single();
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk);
    model_step(1'b0, 1'b0);
    #1;
    in2  = 32'hDEADBEEF;
    req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      model_step(1'b0, 1'b1);
      #1;
      checks++;
      if ({gnt0, gnt1, sel, out} !== {3'b011, 32'hDEADBEEF}) begin
        errors++;
        $display("FAIL single_grant[%0d]: dut=%h exp=%h", i, {gnt0, gnt1, sel, out}, {3'b011, 32'hDEADBEEF});
      end
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL single_model[%0d]: dut=%h exp=%h", i, dut_vec, model_vec());
      end
    end
    req1 = 1'b0;
    @(posedge clk);
    model_step(1'b0, 1'b0);
    #1;
    checks++;
    if ({gnt0, gnt1, sel, busy} !== 4'b0010) begin
      errors++;
      $display("FAIL single_release: dut=%b exp=0010", {gnt0, gnt1, sel, busy});
    end
  endtask

  task automatic test_tie();
    in1  = $urandom;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      model_step(1'b1, 1'b1);
      #1;
      checks++;
      if ({gnt0, gnt1, sel, out} !== {3'b100, in1}) begin
        errors++;
        $display("FAIL tie_g0[%0d]: dut=%h exp=%h", i, {gnt0, gnt1, sel, out}, {3'b100, in1});
      end
    end
    req0 = 1'b0;
    @(posedge clk);
    model_step(1'b0, 1'b1);
    #1;
    checks++;
    if ({gnt0, gnt1, sel, busy} !== 4'b0111) begin
      errors++;
      $display("FAIL tie_handover: dut=%b exp=0111", {gnt0, gnt1, sel, busy});
    end
    req1 = 1'b0;
    @(posedge clk);
    model_step(1'b0, 1'b0);
    #1;
    checks++;
    if (dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL tie_idle: dut=%h exp=%h", dut_vec, model_vec());
    end
  endtask

  task automatic test_mid_reset();
    req1 = 1'b1;
    @(posedge clk);
    model_step(1'b0, 1'b1);
    #1;
    checks++;
    if ({gnt1, sel} !== 2'b11) begin
      errors++;
      $display("FAIL midrst_pre: gnt1,sel=%b exp=11", {gnt1, sel});
    end
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({gnt0, gnt1, sel, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_async: dut=%b exp=0000", {gnt0, gnt1, sel, busy});
    end
    req1 = 1'b0;
    rst  = 1'b1;
    @(posedge clk);
    model_step(1'b0, 1'b0);
    #1;
  endtask

  task automatic test_hold();
    bit exp_g0;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      in1 = $urandom;
      in2 = $urandom;
      @(posedge clk);
      model_step(1'b1, 1'b1);
      #1;
      exp_g0 = TO_EN ? (((i - 1) / TB_HOLD) % 2 == 0) : 1'b1;
      checks++;
      if ({gnt0, gnt1} !== {exp_g0, ~exp_g0}) begin
        errors++;
        $display("FAIL hold_pattern[%0d]: gnt=%b exp=%b", i, {gnt0, gnt1}, {exp_g0, ~exp_g0});
      end
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL hold_model[%0d]: dut=%h exp=%h", i, dut_vec, model_vec());
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk);
    model_step(1'b0, 1'b0);
    #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req0 = ~req0;
      if ($urandom_range(0, 3) == 0) req1 = ~req1;
      in1 = $urandom;
      in2 = $urandom;
      @(posedge clk);
      model_step(req0, req1);
      #1;
      checks++;
      if (dut_vec !== model_vec() || (gnt0 && gnt1)) begin
        errors++;
        $display("FAIL random[%0d]: dut=%h exp=%h", i, dut_vec, model_vec());
      end
      in1 = $urandom;
      in2 = $urandom;
      #1;
      checks++;
      if (out !== (m_sel ? in2 : in1)) begin
        errors++;
        $display("FAIL random_out[%0d]: dut=%h exp=%h", i, out, (m_sel ? in2 : in1));
      end
    end
  endtask

  initial begin
    rst  = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    in1  = '0;
    in2  = '0;
    model_reset();
    test_reset();
    test_single();
    test_tie();
    test_mid_reset();
    test_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
